// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard controller.
//   state_e      : controller state encoding (also driven on the state output)
//   PTS_*        : point values carried by the add buttons
//   BTN_*        : bit positions of the buttons in the edge-detected vector
//   pick_points  : resolves simultaneous add edges to a single point value
package scoreboard_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_VIOL  = 3'd3,
      ST_END   = 3'd4
   } state_e;

   localparam logic [1:0] PTS_1 = 2'd1;
   localparam logic [1:0] PTS_2 = 2'd2;
   localparam logic [1:0] PTS_3 = 2'd3;

   localparam int BTN_ADD_1 = 0;
   localparam int BTN_ADD_2 = 1;
   localparam int BTN_ADD_3 = 2;
   localparam int BTN_UNDO  = 3;

   // Lowest point value wins when several add buttons rise together.
   // Returns 0 when no add edge is present.
   function automatic logic [1:0] pick_points(input logic [2:0] add_rise);
      if (add_rise[BTN_ADD_1])
         return PTS_1;
      else if (add_rise[BTN_ADD_2])
         return PTS_2;
      else if (add_rise[BTN_ADD_3])
         return PTS_3;
      else
         return 2'd0;
   endfunction

endpackage

// File: rtl/scoreboard_ctrl_edge_detect.sv
// Rising-edge detector for a vector of level inputs.
//   clk    : system clock
//   rst    : synchronous active-high reset, clears the history to 0
//   sig_in : level inputs
//   rise   : one-cycle pulse per bit when that bit goes 0 -> 1
// A level that is already high when reset releases produces one pulse,
// because the history restarts at 0.
module edge_detect #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] hist_q;
   logic [WIDTH-1:0] hist_d;

   always_comb hist_d = sig_in;

   always_ff @(posedge clk) begin
      if (rst)
         hist_q <= '0;
      else
         hist_q <= hist_d;
   end

   assign rise = sig_in & ~hist_q;

endmodule

// File: rtl/scoreboard_ctrl.sv
// Game scoreboard controller: game clock, shot clock, per-team scores with
// a one-deep undo, and a buzzer for shot violations / end of game.
//   clk, rst        : system clock, synchronous active-high reset
//   tick_1hz        : one-cycle 1 Hz enable
//   run             : game running level
//   poss            : per-team possession switches (rising edge reloads shot clock)
//   add_1/2/3, undo : debounced score buttons (rising edge acts)
//   team_sel        : team receiving score / undo
//   shot_rst        : rising edge reloads shot clock
//   score           : team i score in bits [i*SW +: SW]
//   shot_clock, game_clock, state, buzzer : registered status outputs
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for run
// ST_RUN   | clocks count on tick_1hz
// ST_PAUSE | clocks stopped, run resumes
// ST_VIOL  | shot clock expired, frozen until a reload event
// ST_END   | game clock expired, everything frozen until reset
module scoreboard_ctrl
   import scoreboard_pkg::*;
#(
   parameter  int NUM_TEAMS = 2,
   parameter  int SCORE_MAX = 99,
   parameter  int SHOT_SEC  = 24,
   parameter  int GAME_SEC  = 600,
   localparam int SW = $clog2(SCORE_MAX + 1),
   localparam int CW = $clog2(SHOT_SEC + 1),
   localparam int GW = $clog2(GAME_SEC + 1),
   localparam int TW = (NUM_TEAMS > 2) ? $clog2(NUM_TEAMS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick_1hz,
   input  logic                    run,
   input  logic [NUM_TEAMS-1:0]    poss,
   input  logic                    add_1,
   input  logic                    add_2,
   input  logic                    add_3,
   input  logic                    undo,
   input  logic [TW-1:0]           team_sel,
   input  logic                    shot_rst,
   output logic [NUM_TEAMS*SW-1:0] score,
   output logic [CW-1:0]           shot_clock,
   output logic [GW-1:0]           game_clock,
   output logic [2:0]              state,
   output logic                    buzzer
);

   state_e          state_q, state_d;
   logic [SW-1:0]   score_q [NUM_TEAMS];
   logic [SW-1:0]   score_d [NUM_TEAMS];
   logic [CW-1:0]   shot_q, shot_d;
   logic [GW-1:0]   game_q, game_d;
   logic            buzzer_q, buzzer_d;
   logic            undo_vld_q, undo_vld_d;
   logic [TW-1:0]   undo_team_q, undo_team_d;
   logic [1:0]      undo_delta_q, undo_delta_d;

   logic [3:0]           btn_rise;
   logic [NUM_TEAMS-1:0] poss_rise;
   logic                 shot_rst_rise;

   edge_detect #(.WIDTH(4)) u_edge_btn (
      .clk    (clk),
      .rst    (rst),
      .sig_in ({undo, add_3, add_2, add_1}),
      .rise   (btn_rise)
   );

   edge_detect #(.WIDTH(NUM_TEAMS)) u_edge_poss (
      .clk    (clk),
      .rst    (rst),
      .sig_in (poss),
      .rise   (poss_rise)
   );

   edge_detect #(.WIDTH(1)) u_edge_shot_rst (
      .clk    (clk),
      .rst    (rst),
      .sig_in (shot_rst),
      .rise   (shot_rst_rise)
   );

   // ---------------- clocks and state ----------------
   logic reload;
   logic shot_dec;
   logic game_last;
   logic shot_last;

   always_comb begin
      reload    = (|poss_rise) | shot_rst_rise;
      // A reload in the same cycle as a tick wins, so the decrement is suppressed.
      shot_dec  = tick_1hz & (|poss) & ~reload & (shot_q != '0);
      game_last = tick_1hz & (game_q <= GW'(1));
      shot_last = shot_dec & (shot_q == CW'(1));

      state_d = state_q;
      shot_d  = shot_q;
      game_d  = game_q;

      unique case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (tick_1hz && (game_q != '0)) game_d = game_q - GW'(1);
            if (shot_dec)                   shot_d = shot_q - CW'(1);
            // Game expiry outranks a shot violation on the same tick.
            if (game_last)
               state_d = ST_END;
            else if (shot_last)
               state_d = ST_VIOL;
            else if (!run)
               state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (run) state_d = ST_RUN;
         end
         ST_VIOL: begin
            if (reload) state_d = ST_PAUSE;
         end
         ST_END: begin
         end
         default: state_d = ST_IDLE;
      endcase

      if (reload && (state_q != ST_END)) shot_d = CW'(SHOT_SEC);

      buzzer_d = (state_d == ST_VIOL) || (state_d == ST_END);
   end

   // ---------------- scoring and undo ----------------
   logic          team_ok;
   logic [1:0]    pts;
   logic [SW-1:0] cur_score;
   logic [SW-1:0] cur_undo_score;
   logic [SW:0]   sum;
   logic [SW-1:0] new_score;
   logic [SW-1:0] undo_score;

   always_comb begin
      score_d      = score_q;
      undo_vld_d   = undo_vld_q;
      undo_team_d  = undo_team_q;
      undo_delta_d = undo_delta_q;

      team_ok = ({1'b0, team_sel} < (TW + 1)'(NUM_TEAMS));
      pts     = pick_points(btn_rise[2:0]);

      cur_score      = '0;
      cur_undo_score = '0;
      for (int i = 0; i < NUM_TEAMS; i++) begin
         if (TW'(i) == team_sel)    cur_score      = score_q[i];
         if (TW'(i) == undo_team_q) cur_undo_score = score_q[i];
      end

      sum       = {1'b0, cur_score} + (SW + 1)'(pts);
      new_score = (sum > (SW + 1)'(SCORE_MAX)) ? SW'(SCORE_MAX) : sum[SW-1:0];
      undo_score = (cur_undo_score > SW'(undo_delta_q)) ?
                   (cur_undo_score - SW'(undo_delta_q)) : '0;

      // An invalid team_sel blocks undo too, even though undo targets the recorded team.
      if ((state_q != ST_END) && team_ok) begin
         if (pts != 2'd0) begin
            for (int i = 0; i < NUM_TEAMS; i++)
               if (TW'(i) == team_sel) score_d[i] = new_score;
            // Record what was actually added, which is less than pts near saturation.
            undo_vld_d   = 1'b1;
            undo_team_d  = team_sel;
            undo_delta_d = 2'(new_score - cur_score);
         end else if (btn_rise[BTN_UNDO] && undo_vld_q) begin
            for (int i = 0; i < NUM_TEAMS; i++)
               if (TW'(i) == undo_team_q) score_d[i] = undo_score;
            undo_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shot_q       <= CW'(SHOT_SEC);
         game_q       <= GW'(GAME_SEC);
         buzzer_q     <= 1'b0;
         undo_vld_q   <= 1'b0;
         undo_team_q  <= '0;
         undo_delta_q <= '0;
         for (int i = 0; i < NUM_TEAMS; i++) score_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         shot_q       <= shot_d;
         game_q       <= game_d;
         buzzer_q     <= buzzer_d;
         undo_vld_q   <= undo_vld_d;
         undo_team_q  <= undo_team_d;
         undo_delta_q <= undo_delta_d;
         score_q      <= score_d;
      end
   end

   for (genvar g = 0; g < NUM_TEAMS; g++) begin : g_score
      assign score[g*SW +: SW] = score_q[g];
   end

   assign state      = state_q;
   assign shot_clock = shot_q;
   assign game_clock = game_q;
   assign buzzer     = buzzer_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
module tb_scoreboard_ctrl;

   localparam int NT   = 3;
   localparam int SMAX = 99;
   localparam int SHOT = 24;
   localparam int GAME = 100;
   localparam int SW   = $clog2(SMAX + 1);
   localparam int CW   = $clog2(SHOT + 1);
   localparam int GW   = $clog2(GAME + 1);
   localparam int TW   = 2;

   logic clk = 1'b0;
   logic rst, tick_1hz, run, add_1, add_2, add_3, undo, shot_rst;
   logic [NT-1:0]    poss;
   logic [TW-1:0]    team_sel;
   logic [NT*SW-1:0] score;
   logic [CW-1:0]    shot_clock;
   logic [GW-1:0]    game_clock;
   logic [2:0]       state;
   logic             buzzer;

   always #5 clk = ~clk;

   scoreboard_ctrl #(
      .NUM_TEAMS(NT), .SCORE_MAX(SMAX), .SHOT_SEC(SHOT), .GAME_SEC(GAME)
   ) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .run(run), .poss(poss),
      .add_1(add_1), .add_2(add_2), .add_3(add_3), .undo(undo),
      .team_sel(team_sel), .shot_rst(shot_rst), .score(score),
      .shot_clock(shot_clock), .game_clock(game_clock), .state(state),
      .buzzer(buzzer)
   );

   typedef struct {
      int s0; int s1; int s2; int shot; int game; int st; int buz;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: 0 IDLE, 1 RUN, 2 PAUSE, 3 VIOL, 4 END
   int   m_sc[NT];
   int   m_shot, m_game, m_st, m_buz;
   bit   u_vld;
   int   u_team, u_delta;
   logic p_a1, p_a2, p_a3, p_un, p_sr;
   logic [NT-1:0] p_poss;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sc_of(input int t);
      return int'(score[t*SW +: SW]);
   endfunction

   task automatic model_step();
      exp_t e;
      bit   e1, e2, e3, eu, reload;
      int   nst, team, k, nv;
      if (rst) begin
         for (int i = 0; i < NT; i++) m_sc[i] = 0;
         m_shot = SHOT; m_game = GAME; m_st = 0; m_buz = 0; u_vld = 0;
         u_team = 0; u_delta = 0;
         p_a1 = 0; p_a2 = 0; p_a3 = 0; p_un = 0; p_sr = 0; p_poss = '0;
      end else begin
         e1 = add_1 && !p_a1;
         e2 = add_2 && !p_a2;
         e3 = add_3 && !p_a3;
         eu = undo && !p_un;
         reload = ((poss & ~p_poss) != '0) || (shot_rst && !p_sr);
         nst  = m_st;
         team = int'(team_sel);
         case (m_st)
            0: if (run) nst = 1;
            1: begin
               if (tick_1hz) begin
                  m_game = m_game - 1;
                  if (m_game == 0) nst = 4;
                  if (poss != '0 && !reload) begin
                     m_shot = m_shot - 1;
                     if (m_shot == 0 && nst != 4) nst = 3;
                  end
               end
               if (nst == 1 && !run) nst = 2;
            end
            2: if (run) nst = 1;
            3: if (reload) nst = 2;
            default: ;
         endcase
         if (reload && m_st != 4) m_shot = SHOT;
         if (m_st != 4 && team < NT) begin
            k = e1 ? 1 : e2 ? 2 : e3 ? 3 : 0;
            if (k != 0) begin
               nv = m_sc[team] + k;
               if (nv > SMAX) nv = SMAX;
               u_delta = nv - m_sc[team];
               u_team = team;
               u_vld = 1;
               m_sc[team] = nv;
            end else if (eu && u_vld) begin
               nv = m_sc[u_team] - u_delta;
               m_sc[u_team] = (nv < 0) ? 0 : nv;
               u_vld = 0;
            end
         end
         m_st  = nst;
         m_buz = (nst == 3 || nst == 4) ? 1 : 0;
         p_a1 = add_1; p_a2 = add_2; p_a3 = add_3; p_un = undo;
         p_sr = shot_rst; p_poss = poss;
      end
      e.s0 = m_sc[0]; e.s1 = m_sc[1]; e.s2 = m_sc[2];
      e.shot = m_shot; e.game = m_game; e.st = m_st; e.buz = m_buz;
      exp_q.push_back(e);
   endtask

   // Monitor: the DUT presents a fresh registered snapshot after every edge.
   exp_t mon_e;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 0, 1);
      end else begin
         mon_e = exp_q.pop_front();
         chk("score0", sc_of(0), mon_e.s0);
         chk("score1", sc_of(1), mon_e.s1);
         chk("score2", sc_of(2), mon_e.s2);
         chk("shot_clock", int'(shot_clock), mon_e.shot);
         chk("game_clock", int'(game_clock), mon_e.game);
         chk("state", int'(state), mon_e.st);
         chk("buzzer", int'(buzzer), mon_e.buz);
      end
   end

   // Inputs are changed at the falling edge, predicted, then clocked in.
   task automatic cyc();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick_1hz = 1'b1; cyc();
         tick_1hz = 1'b0; cyc();
      end
   endtask

   task automatic pulse_add(input int k);
      if (k == 1) add_1 = 1'b1; else if (k == 2) add_2 = 1'b1; else add_3 = 1'b1;
      cyc();
      add_1 = 1'b0; add_2 = 1'b0; add_3 = 1'b0;
      cyc();
   endtask

   task automatic pulse_undo();
      undo = 1'b1; cyc();
      undo = 1'b0; cyc();
   endtask

   task automatic clear_inputs();
      tick_1hz = 0; run = 0; poss = '0; add_1 = 0; add_2 = 0; add_3 = 0;
      undo = 0; shot_rst = 0; team_sel = '0;
   endtask

   logic prev_tick;

   initial begin
      clear_inputs();
      rst = 1'b1;
      cyc(); cyc();
      chk("reset_state", int'(state), 0);
      chk("reset_shot", int'(shot_clock), SHOT);
      chk("reset_game", int'(game_clock), GAME);
      chk("reset_buzzer", int'(buzzer), 0);

      // Shot-clock violation and recovery.
      rst = 1'b0; run = 1'b1; poss = 3'b001;
      cyc();
      chk("idle_to_run", int'(state), 1);
      ticks(24);
      chk("viol_shot", int'(shot_clock), 0);
      chk("viol_state", int'(state), 3);
      chk("viol_buzzer", int'(buzzer), 1);
      poss = 3'b011;
      cyc();
      chk("viol_to_pause", int'(state), 2);
      chk("pause_shot", int'(shot_clock), SHOT);
      chk("pause_buzzer", int'(buzzer), 0);
      cyc();
      chk("pause_to_run", int'(state), 1);

      // Reload coincident with a tick at shot_clock 10.
      ticks(14);
      chk("shot_at_10", int'(shot_clock), 10);
      poss = 3'b111; tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      chk("reload_beats_tick", int'(shot_clock), SHOT);
      chk("game_after_tick", int'(game_clock), GAME - 24 - 14 - 1);

      // Saturation and undo on team 1.
      team_sel = 2'd1;
      repeat (32) pulse_add(3);
      pulse_add(2);
      chk("score1_98", sc_of(1), 98);
      pulse_add(3);
      chk("score1_sat", sc_of(1), 99);
      pulse_undo();
      chk("undo_applied", sc_of(1), 98);
      pulse_undo();
      chk("undo_empty", sc_of(1), 98);

      // Simultaneous add_1 and add_3.
      team_sel = 2'd0; add_1 = 1'b1; add_3 = 1'b1;
      cyc();
      chk("add1_priority", sc_of(0), 1);
      add_1 = 1'b0; add_3 = 1'b0;
      cyc();

      // Held add_2 acts once.
      team_sel = 2'd2; add_2 = 1'b1;
      repeat (100) cyc();
      add_2 = 1'b0;
      cyc();
      chk("held_add2", sc_of(2), 2);

      // Out-of-range team is ignored, undo included.
      team_sel = 2'd3;
      pulse_add(1);
      pulse_undo();
      chk("bad_team_s0", sc_of(0), 1);
      chk("bad_team_s2", sc_of(2), 2);

      // Randomised traffic against the model.
      prev_tick = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 299) == 0);
         tick_1hz = !prev_tick && ($urandom_range(0, 3) == 0);
         prev_tick = tick_1hz;
         if ($urandom_range(0, 19) == 0) run = ~run;
         if ($urandom_range(0, 9) == 0) poss = NT'($urandom);
         add_1    = ($urandom_range(0, 5) == 0);
         add_2    = ($urandom_range(0, 5) == 0);
         add_3    = ($urandom_range(0, 5) == 0);
         undo     = ($urandom_range(0, 4) == 0);
         shot_rst = ($urandom_range(0, 15) == 0);
         team_sel = TW'($urandom_range(0, 3));
         cyc();
      end

      // Game expiry freezes everything.
      clear_inputs();
      rst = 1'b1; cyc();
      rst = 1'b0; run = 1'b1;
      cyc();
      ticks(GAME);
      chk("end_state", int'(state), 4);
      chk("end_buzzer", int'(buzzer), 1);
      chk("end_game", int'(game_clock), 0);
      pulse_add(1);
      chk("end_score_frozen", sc_of(0), 0);
      shot_rst = 1'b1; cyc(); shot_rst = 1'b0; cyc();
      chk("end_still", int'(state), 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 Param NUM_TEAMS, default 2, number of teams (2..8).
REQ-002 Param SCORE_MAX, default 99, per-team score ceiling.
REQ-003 Param SHOT_SEC, default 24, shot-clock reload value (seconds).
REQ-004 Param GAME_SEC, default 600, game-clock reload value (seconds).
REQ-005 Derived: SW=$clog2(SCORE_MAX+1), CW=$clog2(SHOT_SEC+1), GW=$clog2(GAME_SEC+1), TW=max(1,$clog2(NUM_TEAMS)).
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 tick_1hz  in  1  one-cycle-wide 1 Hz enable.
REQ-009 run  in  1  level: game running when high.
REQ-010 poss  in  NUM_TEAMS  per-team possession switch levels.
REQ-011 add_1, add_2, add_3, undo  in  1 each  debounced button levels.
REQ-012 team_sel  in  TW  team receiving score/undo.
REQ-013 shot_rst  in  1  level; rising edge reloads shot clock.
REQ-014 score  out  NUM_TEAMS*SW  team i score in bits [i*SW +: SW].
REQ-015 shot_clock  out  CW; game_clock  out  GW; state  out  3; buzzer  out  1.

Function
REQ-016 Buttons, poss bits and shot_rst SHALL be rising-edge detected internally; a held level acts once.
REQ-017 States: IDLE, RUN, PAUSE, VIOL, END; IDLE->RUN on run=1; RUN->PAUSE on run=0; PAUSE->RUN on run=1.
REQ-018 RUN: on tick_1hz game_clock decrements; reaching 0 -> END (END takes precedence over VIOL in the same cycle).
REQ-019 RUN: on tick_1hz with any poss bit high, shot_clock decrements; reaching 0 -> VIOL.
REQ-020 Shot clock reloads to SHOT_SEC on any poss rising edge or shot_rst rising edge, in any state except END; reload wins over same-cycle decrement.
REQ-021 VIOL: clocks frozen; reload event -> PAUSE with shot_clock=SHOT_SEC.
REQ-022 END: clocks, scores frozen; only rst exits.
REQ-023 Scoring in all states except END: add_k edge adds k to score[team_sel], saturating at SCORE_MAX.
REQ-024 Priority on simultaneous edges: add_1 > add_2 > add_3 > undo; only one acts per cycle.
REQ-025 Each add records (team_sel, applied delta) in a one-deep undo register; applied delta = actual increase after saturation.
REQ-026 undo edge subtracts the recorded delta from the recorded team (floor 0) and clears the register; undo with empty register is a no-op.
REQ-027 team_sel >= NUM_TEAMS: score/undo actions ignored.
REQ-028 buzzer high while state is VIOL or END.
REQ-029 All outputs registered; score/state change one cycle after the causing edge.

Reset
REQ-030 rst: state=IDLE, all scores 0, shot_clock=SHOT_SEC, game_clock=GAME_SEC, buzzer=0, undo register empty, edge-detect history = 0.
REQ-031 rst mid-operation overrides all events in the same cycle.

Structure
REQ-032 Package scoreboard_pkg: state encoding (IDLE=0..END=4), point constants 1/2/3.
REQ-033 One sub-module: edge_detect (parametrised width, rising-edge pulse out), instantiated for buttons, poss, shot_rst.

Verification
REQ-034 Reset, run=1, poss[0]=1, 24 ticks -> shot_clock 24->0, state VIOL, buzzer=1; toggle poss[1] -> PAUSE, shot_clock=24.
REQ-035 score[1]=98, team_sel=1, add_3 edge -> score[1]=99; undo -> 98; second undo -> 98.
REQ-036 add_1 and add_3 rising same cycle, team_sel=0, score 0 -> score[0]=1.
REQ-037 add_2 held 100 cycles -> score increases by exactly 2.
REQ-038 GAME_SEC=5, run=1, 5 ticks -> END, buzzer=1; add_1 edge -> score unchanged.
REQ-039 Poss rising edge coincident with tick_1hz at shot_clock=10 -> shot_clock=24.
